// File: rtl/snake_dir_scheduler_if.sv
// snake_dir_scheduler_if: press pulses and pause in, heading, step and queue depth out
// Ports: pause, up_p/down_p/left_p/right_p (one-cycle press pulses);
//        U/D/L/R (one-hot heading), step (tick strobe), q_count (pending turns)
interface snake_dir_scheduler_if;
    logic       pause;
    logic       up_p;
    logic       down_p;
    logic       left_p;
    logic       right_p;
    logic       U;
    logic       D;
    logic       L;
    logic       R;
    logic       step;
    logic [1:0] q_count;
    modport slave (input pause, up_p, down_p, left_p, right_p, output U, D, L, R, step, q_count);
    modport master (output pause, up_p, down_p, left_p, right_p, input U, D, L, R, step, q_count);
endinterface

// File: rtl/snake_dir_scheduler.sv
// snake_dir_scheduler: arbitrates button presses into a 2-deep turn queue and applies one turn per game tick
// Ports: clock, reset_n (async active-low), bus (slave modport of snake_dir_scheduler_if)
//        carrying pause, press pulses, one-hot heading U/D/L/R, step strobe and q_count.
module snake_dir_scheduler #(
    parameter int TICK_DIV = 25000000,
    parameter int TICK_W   = 25
) (
    input logic                  clock,
    input logic                  reset_n,
    snake_dir_scheduler_if.slave bus
);
    logic [TICK_W-1:0] tickCnt;
    logic [3:0]        heading;
    logic [1:0]        q0, q1, qCount, headCode, refDir, cand;
    logic              stepReg, candValid, wrap, push, pop;
    always_comb begin
        headCode  = heading[3] ? 2'd0 : heading[2] ? 2'd1 : heading[1] ? 2'd2 : 2'd3;
        refDir    = (qCount == 2'd0) ? headCode : (qCount == 2'd1) ? q0 : q1;
        candValid = bus.up_p | bus.down_p | bus.left_p | bus.right_p;
        cand      = bus.up_p ? 2'd0 : bus.down_p ? 2'd1 : bus.left_p ? 2'd2 : 2'd3;
        // opposite directions differ only in bit 0 (Up/Down, Left/Right)
        push      = candValid && qCount != 2'd2 && cand != refDir && cand != (refDir ^ 2'd1);
        wrap      = !bus.pause && tickCnt == TICK_W'(TICK_DIV - 1);
        pop       = wrap && qCount != 2'd0;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tickCnt <= '0;
            stepReg <= 1'b0;
            heading <= 4'b0001;
            q0      <= 2'd0;
            q1      <= 2'd0;
            qCount  <= 2'd0;
        end else begin
            if (!bus.pause) tickCnt <= wrap ? '0 : tickCnt + 1'b1;
            stepReg <= wrap;
            if (pop) heading <= 4'b1000 >> q0;
            // push with pop only happens at depth 1, so the new entry lands at head
            if (pop && push) q0 <= cand;
            else if (pop) q0 <= q1;
            else if (push && qCount == 2'd0) q0 <= cand;
            else if (push) q1 <= cand;
            qCount <= qCount + {1'b0, push} - {1'b0, pop};
        end
    end
    assign bus.U       = heading[3];
    assign bus.D       = heading[2];
    assign bus.L       = heading[1];
    assign bus.R       = heading[0];
    assign bus.step    = stepReg;
    assign bus.q_count = qCount;
endmodule

// File: tb/tb_snake_dir_scheduler.sv
// tb_snake_dir_scheduler: scenario tasks against a scoreboard of expected {U,D,L,R,step,q_count}
module tb_snake_dir_scheduler;
    localparam logic [3:0] HU = 4'b1000, HD = 4'b0100, HL = 4'b0010, HR = 4'b0001;
    localparam logic [3:0] PU = 4'b1000, PD = 4'b0100, PL = 4'b0010, PR = 4'b0001, PN = 4'b0000;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int nChecks = 0;
    int nFail = 0;
    logic [6:0] sb[$];
    snake_dir_scheduler_if bus();
    snake_dir_scheduler #(.TICK_DIV(4), .TICK_W(3)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;

    function automatic logic [6:0] obs();
        return {bus.U, bus.D, bus.L, bus.R, bus.step, bus.q_count};
    endfunction

    task automatic drive(input logic [3:0] p, input logic ps);
        {bus.up_p, bus.down_p, bus.left_p, bus.right_p} = p;
        bus.pause = ps;
    endtask

    task automatic doReset();
        drive(PN, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        doReset();
        for (int k = 1; k <= 12; k++) begin
            sb.push_back({HR, k % 4 == 0, 2'd0});
            @(posedge clock); #1;
            e = sb.pop_front();
            nChecks++;
            if (obs() !== e) begin nFail++; $display("FAIL reset_ticks[%0d] got %b want %b", k, obs(), e); end
        end
    endtask

    task automatic test_two_turns();
        logic [3:0] p[8] = '{PU, PL, PN, PN, PN, PN, PN, PN};
        logic [6:0] x[8] = '{{HR,3'b001}, {HR,3'b010}, {HR,3'b010}, {HU,3'b101},
                             {HU,3'b001}, {HU,3'b001}, {HU,3'b001}, {HL,3'b100}};
        logic [6:0] e;
        doReset();
        for (int i = 0; i < 8; i++) begin
            drive(p[i], 1'b0);
            sb.push_back(x[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            nChecks++;
            if (obs() !== e) begin nFail++; $display("FAIL two_turns[%0d] got %b want %b", i, obs(), e); end
        end
    endtask

    task automatic test_reject();
        logic [3:0] p[8] = '{PL, PR, PN, PN, PD, PN, PN, PN};
        logic [6:0] x[8] = '{{HR,3'b000}, {HR,3'b000}, {HR,3'b000}, {HR,3'b100},
                             {HR,3'b001}, {HR,3'b001}, {HR,3'b001}, {HD,3'b100}};
        logic [6:0] e;
        doReset();
        for (int i = 0; i < 8; i++) begin
            drive(p[i], 1'b0);
            sb.push_back(x[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            nChecks++;
            if (obs() !== e) begin nFail++; $display("FAIL reject[%0d] got %b want %b", i, obs(), e); end
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] p[8] = '{PU | PL, PL, PD, PD, PN, PN, PN, PN};
        logic [6:0] x[8] = '{{HR,3'b001}, {HR,3'b010}, {HR,3'b010}, {HU,3'b101},
                             {HU,3'b001}, {HU,3'b001}, {HU,3'b001}, {HL,3'b100}};
        logic [6:0] e;
        doReset();
        for (int i = 0; i < 8; i++) begin
            drive(p[i], 1'b0);
            sb.push_back(x[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            nChecks++;
            if (obs() !== e) begin nFail++; $display("FAIL arbitration[%0d] got %b want %b", i, obs(), e); end
        end
    endtask

    task automatic test_pause();
        logic [6:0] e;
        doReset();
        for (int i = 0; i < 18; i++) begin
            drive(i == 0 ? PU : i == 5 ? PL : PN, i >= 1 && i <= 10);
            sb.push_back(i == 0 ? {HR,3'b001} : i < 5 ? {HR,3'b001} : i < 13 ? {HR,3'b010} :
                         i == 13 ? {HU,3'b101} : i < 17 ? {HU,3'b001} : {HL,3'b100});
            @(posedge clock); #1;
            e = sb.pop_front();
            nChecks++;
            if (obs() !== e) begin nFail++; $display("FAIL pause[%0d] got %b want %b", i, obs(), e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] p[8] = '{PU, PN, PN, PL, PN, PN, PN, PN};
        logic [6:0] x[8] = '{{HR,3'b001}, {HR,3'b001}, {HR,3'b001}, {HU,3'b101},
                             {HU,3'b001}, {HU,3'b001}, {HU,3'b001}, {HL,3'b100}};
        logic [6:0] e;
        doReset();
        for (int i = 0; i < 8; i++) begin
            drive(p[i], 1'b0);
            sb.push_back(x[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            nChecks++;
            if (obs() !== e) begin nFail++; $display("FAIL back_to_back[%0d] got %b want %b", i, obs(), e); end
        end
    endtask

    task automatic test_reset_midtick();
        logic [3:0] p[6] = '{PD, PN, PN, PN, PL, PU};
        logic [6:0] x[6] = '{{HR,3'b001}, {HR,3'b001}, {HR,3'b001}, {HD,3'b100},
                             {HD,3'b001}, {HD,3'b010}};
        logic [6:0] e;
        doReset();
        for (int i = 0; i < 6; i++) begin
            drive(p[i], 1'b0);
            sb.push_back(x[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            nChecks++;
            if (obs() !== e) begin nFail++; $display("FAIL midtick_setup[%0d] got %b want %b", i, obs(), e); end
        end
        drive(PN, 1'b0);
        sb.push_back({HR, 3'b000});
        reset_n = 1'b0;
        #1;
        e = sb.pop_front();
        nChecks++;
        if (obs() !== e) begin nFail++; $display("FAIL midtick_async got %b want %b", obs(), e); end
        #1 reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sb.push_back({HR, k == 4, 2'd0});
            @(posedge clock); #1;
            e = sb.pop_front();
            nChecks++;
            if (obs() !== e) begin nFail++; $display("FAIL midtick_restart[%0d] got %b want %b", k, obs(), e); end
        end
    endtask

    initial begin
        drive(PN, 1'b0);
        test_reset();
        test_two_turns();
        test_reject();
        test_arbitration();
        test_pause();
        test_back_to_back();
        test_reset_midtick();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
